// File: rtl/fir_sequencer_pkg.sv
// Shared types and default sizing for the fir sequencer and its coefficient buffer.
package fir_sequencer_pkg;

  localparam int DEF_DW         = 8;
  localparam int DEF_OW         = 16;
  localparam int DEF_NTAPS      = 5;
  localparam int DEF_SWITCH_CYC = 1;
  localparam int DEF_CW         = 16;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_BURST   = 3'd2,
    S_SWITCH  = 3'd3,
    S_RUN     = 3'd4,
    S_ERR     = 3'd5
  } fir_seq_state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fir_sequencer_if.sv
// Coefficient/sample streams, fir datapath link and status outputs of the fir sequencer.
interface fir_sequencer_if
  import fir_sequencer_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int OW = DEF_OW,
  parameter int CW = DEF_CW
);
  logic          coef_in_valid;
  logic [DW-1:0] coef_in_data;
  logic          coef_in_ready;
  logic          samp_in_valid;
  logic [DW-1:0] samp_in_data;
  logic          samp_in_ready;
  logic [DW-1:0] fir_data_in;
  logic          fir_coef_enable;
  logic          fir_sample_enable;
  logic [OW-1:0] fir_data_out;
  logic          fir_out_enable;
  logic          fir_error;
  logic          clr_err;
  logic [OW-1:0] res_data;
  logic          res_valid;
  logic [CW-1:0] res_count;
  logic          loaded;
  logic          busy;
  logic          err;

  modport master (
    output coef_in_valid, coef_in_data, samp_in_valid, samp_in_data,
           fir_data_out, fir_out_enable, fir_error, clr_err,
    input  coef_in_ready, samp_in_ready, fir_data_in, fir_coef_enable,
           fir_sample_enable, res_data, res_valid, res_count, loaded, busy, err
  );

  modport slave (
    input  coef_in_valid, coef_in_data, samp_in_valid, samp_in_data,
           fir_data_out, fir_out_enable, fir_error, clr_err,
    output coef_in_ready, samp_in_ready, fir_data_in, fir_coef_enable,
           fir_sample_enable, res_data, res_valid, res_count, loaded, busy, err
  );
endinterface

// File: rtl/fir_coef_buffer.sv
// NTAPS x DW coefficient register file: written while collecting, read by the burst index.
module fir_coef_buffer
  import fir_sequencer_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int NTAPS = DEF_NTAPS,
  parameter int IW    = idx_w(DEF_NTAPS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_ptr,
  input  logic [DW-1:0] wr_data,
  input  logic [IW-1:0] rd_idx,
  output logic [DW-1:0] rd_data
);
  logic [DW-1:0] mem_q [NTAPS];
  logic [DW-1:0] mem_d [NTAPS];

  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_ptr] = wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NTAPS; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_data = mem_q[rd_idx];
endmodule

// File: rtl/fir_sequencer.sv
// Sequences coefficient loads and sample streaming into the fir datapath and registers its results.
//   state   | meaning
//   IDLE    | nothing loaded or waiting for a coefficient set
//   COLLECT | accepting NTAPS coefficient words into the buffer
//   BURST   | writing buffer to fir, one word per cycle, no stall
//   SWITCH  | idle gap with both fir enables low
//   RUN     | streaming samples; a new coefficient offer preempts
//   ERR     | fir reported an error; waits for clr_err
module fir_sequencer
  import fir_sequencer_pkg::*;
#(
  parameter int DW         = DEF_DW,
  parameter int OW         = DEF_OW,
  parameter int NTAPS      = DEF_NTAPS,
  parameter int SWITCH_CYC = DEF_SWITCH_CYC,
  parameter int CW         = DEF_CW
) (
  input  logic            clk,
  input  logic            reset,
  fir_sequencer_if.slave  bus
);
  localparam int IW  = idx_w(NTAPS);
  localparam int SWW = idx_w(SWITCH_CYC);
  localparam logic [IW-1:0]  LAST_IDX = IW'(NTAPS - 1);
  localparam logic [SWW-1:0] SW_LOAD  = SWW'(SWITCH_CYC - 1);

  fir_seq_state_t state_q, state_d;
  logic [IW-1:0]  wcnt_q, wcnt_d, bidx_q, bidx_d;
  logic [SWW-1:0] sw_cnt_q, sw_cnt_d;
  logic           coef_en_q, coef_en_d, samp_en_q, samp_en_d;
  logic [DW-1:0]  data_q, data_d;
  logic           loaded_q, loaded_d, busy_q, busy_d, err_q, err_d;
  logic           res_valid_q, res_valid_d;
  logic [OW-1:0]  res_data_q, res_data_d;
  logic [CW-1:0]  res_count_q, res_count_d;

  logic          coef_rdy, samp_rdy, coef_acc, samp_acc;
  logic [DW-1:0] buf_rd;

  assign coef_rdy = (state_q == S_COLLECT);
  // Reload has priority over sampling, decided combinationally on the live coefficient offer.
  assign samp_rdy = (state_q == S_RUN) && !bus.coef_in_valid;
  assign coef_acc = coef_rdy && bus.coef_in_valid;
  assign samp_acc = samp_rdy && bus.samp_in_valid;

  fir_coef_buffer #(.DW(DW), .NTAPS(NTAPS), .IW(IW)) u_buf (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (coef_acc && !bus.fir_error),
    .wr_ptr  (wcnt_q),
    .wr_data (bus.coef_in_data),
    .rd_idx  (bidx_d),
    .rd_data (buf_rd)
  );

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    bidx_d   = bidx_q;
    sw_cnt_d = sw_cnt_q;
    case (state_q)
      S_IDLE: if (bus.coef_in_valid) begin
        state_d = S_COLLECT;
        wcnt_d  = '0;
      end
      S_COLLECT: if (coef_acc) begin
        if (wcnt_q == LAST_IDX) begin
          state_d = S_BURST;
          wcnt_d  = '0;
          bidx_d  = '0;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      S_BURST: if (bidx_q == LAST_IDX) begin
        state_d  = S_SWITCH;
        sw_cnt_d = SW_LOAD;
      end else begin
        bidx_d = bidx_q + 1'b1;
      end
      S_SWITCH: if (sw_cnt_q == '0) state_d = S_RUN;
                else sw_cnt_d = sw_cnt_q - 1'b1;
      S_RUN: if (bus.coef_in_valid) begin
        state_d = S_COLLECT;
        wcnt_d  = '0;
      end
      S_ERR: if (bus.clr_err) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // An error overrides every transition; any partial set is discarded.
    if (state_q != S_IDLE && bus.fir_error) begin
      state_d  = S_ERR;
      wcnt_d   = '0;
      bidx_d   = '0;
      sw_cnt_d = '0;
    end

    coef_en_d = (state_d == S_BURST);
    samp_en_d = samp_acc && !bus.fir_error;
    if (coef_en_d)      data_d = buf_rd;
    else if (samp_en_d) data_d = bus.samp_in_data;
    else                data_d = data_q;

    loaded_d    = (state_d == S_RUN) || (loaded_q && state_d == S_COLLECT);
    busy_d      = (state_d == S_COLLECT) || (state_d == S_BURST) || (state_d == S_SWITCH);
    err_d       = (state_d == S_ERR);
    res_valid_d = bus.fir_out_enable;
    res_data_d  = bus.fir_data_out;
    res_count_d = res_count_q + CW'(res_valid_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wcnt_q      <= '0;
      bidx_q      <= '0;
      sw_cnt_q    <= '0;
      coef_en_q   <= 1'b0;
      samp_en_q   <= 1'b0;
      data_q      <= '0;
      loaded_q    <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_count_q <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      bidx_q      <= bidx_d;
      sw_cnt_q    <= sw_cnt_d;
      coef_en_q   <= coef_en_d;
      samp_en_q   <= samp_en_d;
      data_q      <= data_d;
      loaded_q    <= loaded_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_count_q <= res_count_d;
    end
  end

  assign bus.coef_in_ready     = coef_rdy;
  assign bus.samp_in_ready     = samp_rdy;
  assign bus.fir_data_in       = data_q;
  assign bus.fir_coef_enable   = coef_en_q;
  assign bus.fir_sample_enable = samp_en_q;
  assign bus.res_data          = res_data_q;
  assign bus.res_valid         = res_valid_q;
  assign bus.res_count         = res_count_q;
  assign bus.loaded            = loaded_q;
  assign bus.busy              = busy_q;
  assign bus.err               = err_q;
endmodule

// File: tb/tb_fir_sequencer.sv
// Directed scenario bench for fir_sequencer with a one-cycle-latency fir stand-in.
module tb_fir_sequencer;
  import fir_sequencer_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;

  fir_sequencer_if #(.DW(8), .OW(16), .CW(16)) bus ();

  fir_sequencer dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // fir stand-in: one result per sample one cycle later, value = sample + 0x100
  logic        model_oe = 1'b0;
  logic [15:0] model_od = 16'h0;
  logic        man_oe   = 1'b0;
  always @(posedge clk) begin
    model_oe <= bus.fir_sample_enable;
    model_od <= {8'h00, bus.fir_data_in} + 16'h0100;
  end
  assign bus.fir_out_enable = model_oe | man_oe;
  assign bus.fir_data_out   = model_od;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_coef(input logic [7:0] d);
    int n = 0;
    bus.coef_in_valid = 1'b1;
    bus.coef_in_data  = d;
    while (!bus.coef_in_ready && n < 20) begin
      tick;
      n++;
    end
    checks++; if (n >= 20) begin errors++; $display("FAIL coef_ready_timeout word %0d waited %0d need <20", d, n); end
    tick;
    bus.coef_in_valid = 1'b0;
  endtask

  // Called right after the last word's accept edge: expects BURST cycle 0 visible.
  task automatic check_burst_switch(input logic [7:0] base);
    for (int k = 0; k < 5; k++) begin
      checks++; if (bus.fir_coef_enable !== 1'b1) begin errors++; $display("FAIL burst_en k=%0d got %b exp 1", k, bus.fir_coef_enable); end
      checks++; if (bus.fir_data_in !== base + 8'(k)) begin errors++; $display("FAIL burst_data k=%0d got %0d exp %0d", k, bus.fir_data_in, base + 8'(k)); end
      checks++; if (bus.fir_sample_enable !== 1'b0) begin errors++; $display("FAIL burst_samp_en k=%0d got %b exp 0", k, bus.fir_sample_enable); end
      checks++; if (bus.loaded !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL burst_status k=%0d loaded=%b busy=%b exp 0/1", k, bus.loaded, bus.busy); end
      checks++; if (bus.samp_in_ready !== 1'b0) begin errors++; $display("FAIL burst_samp_ready k=%0d got %b exp 0", k, bus.samp_in_ready); end
      tick;
    end
    checks++; if (bus.fir_coef_enable !== 1'b0 || bus.fir_sample_enable !== 1'b0) begin errors++; $display("FAIL switch_en got %b%b exp 00", bus.fir_coef_enable, bus.fir_sample_enable); end
    checks++; if (bus.loaded !== 1'b0 || bus.busy !== 1'b1 || bus.samp_in_ready !== 1'b0) begin errors++; $display("FAIL switch_status loaded=%b busy=%b srdy=%b exp 0/1/0", bus.loaded, bus.busy, bus.samp_in_ready); end
    tick;
    checks++; if (bus.loaded !== 1'b1 || bus.busy !== 1'b0 || bus.fir_coef_enable !== 1'b0) begin errors++; $display("FAIL run_entry loaded=%b busy=%b cen=%b exp 1/0/0", bus.loaded, bus.busy, bus.fir_coef_enable); end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick; tick;
    reset = 1'b0;
    checks++; if ({bus.fir_coef_enable, bus.fir_sample_enable, bus.loaded, bus.busy, bus.err, bus.res_valid} !== 6'b0)
      begin errors++; $display("FAIL reset_flags got %b exp 000000", {bus.fir_coef_enable, bus.fir_sample_enable, bus.loaded, bus.busy, bus.err, bus.res_valid}); end
    checks++; if (bus.fir_data_in !== 8'h0 || bus.res_data !== 16'h0 || bus.res_count !== 16'h0)
      begin errors++; $display("FAIL reset_data din=%0h rd=%0h rc=%0h exp 0", bus.fir_data_in, bus.res_data, bus.res_count); end
    checks++; if (bus.coef_in_ready !== 1'b0 || bus.samp_in_ready !== 1'b0)
      begin errors++; $display("FAIL reset_ready got %b%b exp 00", bus.coef_in_ready, bus.samp_in_ready); end
  endtask

  task automatic test_load;
    send_coef(8'd4);
    send_coef(8'd5);
    send_coef(8'd6);
    tick; tick;
    checks++; if (bus.fir_coef_enable !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL collect_gap cen=%b busy=%b exp 0/1", bus.fir_coef_enable, bus.busy); end
    send_coef(8'd7);
    send_coef(8'd8);
    check_burst_switch(8'd4);
  endtask

  task automatic test_back_to_back;
    bus.samp_in_valid = 1'b1;
    bus.samp_in_data  = 8'd1;
    #1;
    checks++; if (bus.samp_in_ready !== 1'b1) begin errors++; $display("FAIL run_samp_ready got %b exp 1", bus.samp_in_ready); end
    tick;
    checks++; if (bus.fir_sample_enable !== 1'b1 || bus.fir_data_in !== 8'd1) begin errors++; $display("FAIL samp1 en=%b data=%0d exp 1/1", bus.fir_sample_enable, bus.fir_data_in); end
    tick;
    bus.samp_in_valid = 1'b0;
    checks++; if (bus.fir_sample_enable !== 1'b1 || bus.fir_data_in !== 8'd1 || bus.res_valid !== 1'b0) begin errors++; $display("FAIL samp2 en=%b data=%0d rv=%b exp 1/1/0", bus.fir_sample_enable, bus.fir_data_in, bus.res_valid); end
    tick;
    checks++; if (bus.fir_sample_enable !== 1'b0 || bus.res_valid !== 1'b1 || bus.res_data !== 16'h0101) begin errors++; $display("FAIL res1 sen=%b rv=%b rd=%0h exp 0/1/101", bus.fir_sample_enable, bus.res_valid, bus.res_data); end
    tick;
    checks++; if (bus.res_valid !== 1'b1 || bus.res_count !== 16'd1) begin errors++; $display("FAIL res2 rv=%b rc=%0d exp 1/1", bus.res_valid, bus.res_count); end
    tick;
    checks++; if (bus.res_valid !== 1'b0 || bus.res_count !== 16'd2) begin errors++; $display("FAIL res_count rv=%b rc=%0d exp 0/2", bus.res_valid, bus.res_count); end
  endtask

  task automatic test_reload_priority;
    bus.coef_in_valid = 1'b1;
    bus.coef_in_data  = 8'd10;
    bus.samp_in_valid = 1'b1;
    bus.samp_in_data  = 8'd2;
    #1;
    checks++; if (bus.samp_in_ready !== 1'b0) begin errors++; $display("FAIL prio_samp_ready got %b exp 0", bus.samp_in_ready); end
    tick;
    checks++; if (bus.fir_sample_enable !== 1'b0 || bus.loaded !== 1'b1 || bus.busy !== 1'b1) begin errors++; $display("FAIL prio_collect sen=%b loaded=%b busy=%b exp 0/1/1", bus.fir_sample_enable, bus.loaded, bus.busy); end
    for (int i = 0; i < 5; i++) send_coef(8'(10 + i));
    check_burst_switch(8'd10);
    checks++; if (bus.samp_in_ready !== 1'b1) begin errors++; $display("FAIL held_samp_ready got %b exp 1", bus.samp_in_ready); end
    tick;
    bus.samp_in_valid = 1'b0;
    checks++; if (bus.fir_sample_enable !== 1'b1 || bus.fir_data_in !== 8'd2) begin errors++; $display("FAIL held_samp en=%b data=%0d exp 1/2", bus.fir_sample_enable, bus.fir_data_in); end
    tick; tick; tick;
    checks++; if (bus.res_count !== 16'd3) begin errors++; $display("FAIL held_res_count got %0d exp 3", bus.res_count); end
  endtask

  task automatic test_error;
    send_coef(8'd20);
    send_coef(8'd21);
    send_coef(8'd22);
    checks++; if (bus.loaded !== 1'b1 || bus.busy !== 1'b1) begin errors++; $display("FAIL err_precollect loaded=%b busy=%b exp 1/1", bus.loaded, bus.busy); end
    bus.coef_in_valid = 1'b1;
    bus.coef_in_data  = 8'd23;
    bus.fir_error     = 1'b1;
    tick;
    bus.fir_error     = 1'b0;
    bus.coef_in_valid = 1'b0;
    checks++; if (bus.err !== 1'b1 || bus.loaded !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL err_entry err=%b loaded=%b busy=%b exp 1/0/0", bus.err, bus.loaded, bus.busy); end
    checks++; if (bus.coef_in_ready !== 1'b0 || bus.samp_in_ready !== 1'b0 || bus.fir_coef_enable !== 1'b0) begin errors++; $display("FAIL err_ready crdy=%b srdy=%b cen=%b exp 000", bus.coef_in_ready, bus.samp_in_ready, bus.fir_coef_enable); end
    tick; tick; tick;
    checks++; if (bus.err !== 1'b1 || bus.fir_coef_enable !== 1'b0) begin errors++; $display("FAIL err_sticky err=%b cen=%b exp 1/0", bus.err, bus.fir_coef_enable); end
    bus.clr_err = 1'b1;
    tick;
    bus.clr_err = 1'b0;
    checks++; if (bus.err !== 1'b0 || dut.state_q !== S_IDLE) begin errors++; $display("FAIL err_clear err=%b state=%0d exp 0/IDLE", bus.err, dut.state_q); end
    for (int i = 0; i < 5; i++) send_coef(8'(30 + i));
    check_burst_switch(8'd30);
  endtask

  task automatic test_reset_in_burst;
    int seen = 0;
    for (int i = 0; i < 5; i++) send_coef(8'(40 + i));
    tick; tick;
    checks++; if (bus.fir_coef_enable !== 1'b1 || bus.fir_data_in !== 8'd42) begin errors++; $display("FAIL burst_k2 cen=%b data=%0d exp 1/42", bus.fir_coef_enable, bus.fir_data_in); end
    reset = 1'b1;
    tick;
    reset = 1'b0;
    checks++; if ({bus.fir_coef_enable, bus.fir_sample_enable, bus.loaded, bus.busy, bus.err, bus.res_valid} !== 6'b0 || bus.fir_data_in !== 8'h0 || bus.res_count !== 16'h0)
      begin errors++; $display("FAIL rst_burst flags=%b din=%0h rc=%0h exp 0", {bus.fir_coef_enable, bus.fir_sample_enable, bus.loaded, bus.busy, bus.err, bus.res_valid}, bus.fir_data_in, bus.res_count); end
    checks++; if (dut.state_q !== S_IDLE) begin errors++; $display("FAIL rst_burst_state got %0d exp IDLE", dut.state_q); end
    for (int i = 0; i < 8; i++) begin
      if (bus.fir_coef_enable === 1'b1) seen++;
      tick;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL rst_burst_no_coef_en got %0d cycles exp 0", seen); end
  endtask

  task automatic test_count_wrap;
    force dut.res_count_q = 16'hFFFF;
    man_oe = 1'b1;
    tick;
    release dut.res_count_q;
    man_oe = 1'b0;
    checks++; if (bus.res_valid !== 1'b1 || bus.res_count !== 16'hFFFF) begin errors++; $display("FAIL wrap_pre rv=%b rc=%0h exp 1/ffff", bus.res_valid, bus.res_count); end
    tick;
    checks++; if (bus.res_count !== 16'h0000) begin errors++; $display("FAIL wrap got %0h exp 0", bus.res_count); end
  endtask

  initial begin
    reset             = 1'b1;
    bus.coef_in_valid = 1'b0;
    bus.coef_in_data  = 8'h0;
    bus.samp_in_valid = 1'b0;
    bus.samp_in_data  = 8'h0;
    bus.fir_error     = 1'b0;
    bus.clr_err       = 1'b0;
    test_reset;
    test_load;
    test_back_to_back;
    test_reload_priority;
    test_error;
    test_reset_in_burst;
    test_count_wrap;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout at %0t exp completion", $time);
    $fatal(1);
  end
endmodule
